regfile_sb: RTL

Parametrised MIPS-style register file with two combinational read ports, one clocked write port, write-to-read bypass, a per-register pending-write scoreboard, and a post-reset clearing sweep. It sits in the decode stage. Read ports feed the operand latches, the write port is driven by writeback, and the pending flags drive the decode stall logic.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_sb_if.sv | 33 +++
 rtl/regfile_scoreboard.sv | 47 ++++
 rtl/regfile_sb.sv | 78 +++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the decode-stage register file.
// State encodings and default widths used by decode and writeback.
package regfile_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
endpackage

// File: rtl/regfile_sb_if.sv
// Read, write, issue and status signals of the register file.
// Master drives addresses and strobes; slave is the register file.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] dataout1;
    logic [DATA_W-1:0] dataout2;
    logic              writeEn;
    logic [ADDR_W-1:0] writeAddr;
    logic [DATA_W-1:0] writeData;
    logic              issueEn;
    logic [ADDR_W-1:0] issueAddr;
    logic              pend1;
    logic              pend2;
    logic              busy;

    modport master (
        output addr1, addr2, writeEn, writeAddr, writeData,
        output issueEn, issueAddr,
        input  dataout1, dataout2, pend1, pend2, busy
    );

    modport slave (
        input  addr1, addr2, writeEn, writeAddr, writeData,
        input  issueEn, issueAddr,
        output dataout1, dataout2, pend1, pend2, busy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits with set-over-clear priority
// and bypass-masked lookups for both read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic              pend1,
    output logic              pend2
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] pending;

    // Set is applied last so a new producer supersedes the retiring one.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (clr_en) pending[clr_addr] <= 1'b0;
            if (set_en) pending[set_addr] <= 1'b1;
        end
    end

    function automatic logic lookup(input logic [ADDR_W-1:0] a);
        logic p;
        p = pending[a];
        if (BYPASS != 0 && clr_en && clr_addr == a) p = 1'b0;
        if (ZERO_REG != 0 && a == '0) p = 1'b0;
        return p;
    endfunction

    always_comb begin
        pend1 = lookup(addr1);
        pend2 = lookup(addr2);
    end
endmodule

// File: rtl/regfile_sb.sv
// Two-read one-write register file with bypass, pending-write
// scoreboard and a post-reset sweep that zeroes every entry.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave rf
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [0:0]        state;
    logic [ADDR_W:0]   ptr;
    logic              run;
    logic              wen;
    logic              ien;

    assign run = (state == ST_RUN);
    assign wen = run && rf.writeEn &&
                 !(ZERO_REG != 0 && rf.writeAddr == '0);
    assign ien = run && rf.issueEn &&
                 !(ZERO_REG != 0 && rf.issueAddr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else if (state == ST_CLEAR) begin
            mem[ptr[ADDR_W-1:0]] <= '0;
            ptr <= ptr + 1'b1;
            if (ptr == LAST) state <= ST_RUN;
        end else if (wen) begin
            mem[rf.writeAddr] <= rf.writeData;
        end
    end

    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        d = mem[a];
        if (!run)
            d = '0;
        else if (ZERO_REG != 0 && a == '0)
            d = '0;
        else if (BYPASS != 0 && wen && rf.writeAddr == a)
            d = rf.writeData;
        return d;
    endfunction

    always_comb begin
        rf.dataout1 = rd(rf.addr1);
        rf.dataout2 = rd(rf.addr2);
        rf.busy     = !run;
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (ien),
        .set_addr (rf.issueAddr),
        .clr_en   (wen),
        .clr_addr (rf.writeAddr),
        .addr1    (rf.addr1),
        .addr2    (rf.addr2),
        .pend1    (rf.pend1),
        .pend2    (rf.pend2)
    );
endmodule
